// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the LSU memory-access stage.
//   size_e   - access size encoding presented by the execute stage
//   state_e  - memory-access FSM states
//   NUM_LANES - byte lanes on the 32-bit data-memory port
//   lane_mask - expands per-lane byte enables to a bit mask
package lsu_pkg;

   localparam int unsigned NUM_LANES = 4;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10
   } size_e;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT_R,
      RESP,
      ERR
   } state_e;

   function automatic logic [NUM_LANES*8-1:0] lane_mask(input logic [NUM_LANES-1:0] be);
      logic [NUM_LANES*8-1:0] m;
      for (int i = 0; i < NUM_LANES; i++) begin
         m[i*8 +: 8] = {8{be[i]}};
      end
      return m;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational byte-lane alignment for a 32-bit data port.
//   size          in   access size (00 byte, 01 half, 10 word, 11 illegal)
//   off           in   byte offset within the word
//   load_unsigned in   1 = zero-extend loaded sub-word, 0 = sign-extend
//   wr_data       in   right-justified store data
//   mem_rdata     in   raw word returned by memory
//   mem_be        out  byte enables for the access
//   wdata         out  store data shifted onto its lanes, other lanes zero
//   ldata         out  extracted and extended load data
//   misaligned    out  size/offset combination cannot be issued
module lsu_align
   import lsu_pkg::*;
(
   input  logic [1:0]               size,
   input  logic [1:0]               off,
   input  logic                     load_unsigned,
   input  logic [NUM_LANES*8-1:0]   wr_data,
   input  logic [NUM_LANES*8-1:0]   mem_rdata,
   output logic [NUM_LANES-1:0]     mem_be,
   output logic [NUM_LANES*8-1:0]   wdata,
   output logic [NUM_LANES*8-1:0]   ldata,
   output logic                     misaligned
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = mem_rdata[7:0];
      unique case (off)
         2'd0: byte_sel = mem_rdata[7:0];
         2'd1: byte_sel = mem_rdata[15:8];
         2'd2: byte_sel = mem_rdata[23:16];
         2'd3: byte_sel = mem_rdata[31:24];
         default: byte_sel = mem_rdata[7:0];
      endcase
      // Only offsets 0 and 2 are legal for halves; off[0] is screened by misaligned.
      half_sel = off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
   end

   always_comb begin
      mem_be     = '0;
      ldata      = '0;
      misaligned = 1'b0;
      case (size)
         SZ_BYTE: begin
            mem_be = 4'b0001 << off;
            ldata  = load_unsigned ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
         end
         SZ_HALF: begin
            misaligned = off[0];
            mem_be     = 4'b0011 << off;
            ldata      = load_unsigned ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
         end
         SZ_WORD: begin
            misaligned = (off != 2'd0);
            mem_be     = 4'b1111;
            ldata      = mem_rdata;
         end
         default: begin
            misaligned = 1'b1;
         end
      endcase
   end

   assign wdata = (wr_data << {off, 3'b000}) & lane_mask(mem_be);

endmodule

// File: rtl/lsu_mem_access.sv
// lsu_mem_access: LSU memory-access stage. Takes one load/store at a time from the
// execute stage, issues it on a request/grant/response data-memory port and
// returns extended load data to writeback.
//   clk, rst_n               clock, asynchronous active-low reset
//   in_valid / in_ready      upstream handshake (ready only while idle)
//   rd_en, rd_addr           load request and byte address
//   wr_en, wr_addr, wr_data  store request, byte address, right-justified data
//   size, load_unsigned      access size and load extension mode
//   rd_idx                   load destination register
//   mem_req/we/addr/be/wdata memory request, held until mem_gnt
//   mem_gnt, mem_rvalid, mem_rdata  memory grant and read response
//   wb_valid, wb_idx, wb_data       one-cycle load writeback
//   misalign_err             one-cycle pulse for a rejected transaction
module lsu_mem_access
   import lsu_pkg::*;
#(
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned REG_IDX_W = 6
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 rd_en,
   input  logic [ADDR_W-1:0]    rd_addr,
   input  logic                 wr_en,
   input  logic [ADDR_W-1:0]    wr_addr,
   input  logic [DATA_W-1:0]    wr_data,
   input  logic [1:0]           size,
   input  logic                 load_unsigned,
   input  logic [REG_IDX_W-1:0] rd_idx,
   output logic                 mem_req,
   output logic                 mem_we,
   output logic [ADDR_W-1:0]    mem_addr,
   output logic [3:0]           mem_be,
   output logic [DATA_W-1:0]    mem_wdata,
   input  logic                 mem_gnt,
   input  logic                 mem_rvalid,
   input  logic [DATA_W-1:0]    mem_rdata,
   output logic                 wb_valid,
   output logic [REG_IDX_W-1:0] wb_idx,
   output logic [DATA_W-1:0]    wb_data,
   output logic                 misalign_err
);

   state_e               state_q;
   logic [1:0]           size_q;
   logic [1:0]           off_q;
   logic                 uns_q;
   logic                 is_load_q;
   logic [REG_IDX_W-1:0] idx_q;

   logic [ADDR_W-1:0]    acc_addr;
   logic [1:0]           al_size;
   logic [1:0]           al_off;
   logic                 al_uns;
   logic [3:0]           al_be;
   logic [DATA_W-1:0]    al_wdata;
   logic [DATA_W-1:0]    al_ldata;
   logic                 al_mis;
   logic                 illegal;

   assign acc_addr = rd_en ? rd_addr : wr_addr;

   // One aligner serves both phases: live inputs while idle (request build),
   // latched operands afterwards (load extraction).
   assign al_size = (state_q == IDLE) ? size          : size_q;
   assign al_off  = (state_q == IDLE) ? acc_addr[1:0] : off_q;
   assign al_uns  = (state_q == IDLE) ? load_unsigned : uns_q;

   assign illegal = (rd_en && wr_en) || al_mis;

   lsu_align u_align (
      .size          (al_size),
      .off           (al_off),
      .load_unsigned (al_uns),
      .wr_data       (wr_data),
      .mem_rdata     (mem_rdata),
      .mem_be        (al_be),
      .wdata         (al_wdata),
      .ldata         (al_ldata),
      .misaligned    (al_mis)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         size_q       <= '0;
         off_q        <= '0;
         uns_q        <= 1'b0;
         is_load_q    <= 1'b0;
         idx_q        <= '0;
         in_ready     <= 1'b1;
         mem_req      <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_be       <= '0;
         mem_wdata    <= '0;
         wb_valid     <= 1'b0;
         wb_idx       <= '0;
         wb_data      <= '0;
         misalign_err <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (in_valid) begin
                  size_q    <= size;
                  off_q     <= acc_addr[1:0];
                  uns_q     <= load_unsigned;
                  is_load_q <= rd_en;
                  idx_q     <= rd_idx;
                  if (!rd_en && !wr_en) begin
                     // NOP: consumed with no side effects
                     state_q <= IDLE;
                  end else if (illegal) begin
                     state_q      <= ERR;
                     in_ready     <= 1'b0;
                     misalign_err <= 1'b1;
                  end else begin
                     state_q   <= REQ;
                     in_ready  <= 1'b0;
                     mem_req   <= 1'b1;
                     mem_we    <= wr_en;
                     mem_addr  <= {acc_addr[ADDR_W-1:2], 2'b00};
                     mem_be    <= al_be;
                     mem_wdata <= wr_en ? al_wdata : '0;
                  end
               end
            end
            REQ: begin
               if (mem_gnt) begin
                  mem_req   <= 1'b0;
                  mem_we    <= 1'b0;
                  mem_addr  <= '0;
                  mem_be    <= '0;
                  mem_wdata <= '0;
                  if (is_load_q) begin
                     state_q <= WAIT_R;
                  end else begin
                     state_q  <= IDLE;
                     in_ready <= 1'b1;
                  end
               end
            end
            WAIT_R: begin
               if (mem_rvalid) begin
                  state_q  <= RESP;
                  wb_valid <= 1'b1;
                  wb_idx   <= idx_q;
                  wb_data  <= al_ldata;
               end
            end
            RESP: begin
               state_q  <= IDLE;
               in_ready <= 1'b1;
               wb_valid <= 1'b0;
               wb_idx   <= '0;
               wb_data  <= '0;
            end
            ERR: begin
               state_q      <= IDLE;
               in_ready     <= 1'b1;
               misalign_err <= 1'b0;
            end
            default: begin
               state_q  <= IDLE;
               in_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_mem_access.sv
module tb_lsu_mem_access;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic        rd_en;
   logic [31:0] rd_addr;
   logic        wr_en;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;
   logic [1:0]  size;
   logic        load_unsigned;
   logic [5:0]  rd_idx;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        wb_valid;
   logic [5:0]  wb_idx;
   logic [31:0] wb_data;
   logic        misalign_err;

   lsu_mem_access dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .rd_en         (rd_en),
      .rd_addr       (rd_addr),
      .wr_en         (wr_en),
      .wr_addr       (wr_addr),
      .wr_data       (wr_data),
      .size          (size),
      .load_unsigned (load_unsigned),
      .rd_idx        (rd_idx),
      .mem_req       (mem_req),
      .mem_we        (mem_we),
      .mem_addr      (mem_addr),
      .mem_be        (mem_be),
      .mem_wdata     (mem_wdata),
      .mem_gnt       (mem_gnt),
      .mem_rvalid    (mem_rvalid),
      .mem_rdata     (mem_rdata),
      .wb_valid      (wb_valid),
      .wb_idx        (wb_idx),
      .wb_data       (wb_data),
      .misalign_err  (misalign_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
   } req_t;

   typedef struct {
      logic [5:0]  idx;
      logic [31:0] data;
      int          cyc;
   } wb_t;

   typedef struct {
      int          delay;
      logic [31:0] rdata;
      bit          no_rv;
   } mem_t;

   req_t req_q[$];
   wb_t  wb_q[$];
   int   err_q[$];
   mem_t mem_q[$];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   bit force_rv = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, act, exp, cyc);
      end
   endtask

   // Memory responder: grants after the queued delay, returns read data one cycle later.
   bit          m_active = 0;
   bit          rv_pend  = 0;
   int          m_cnt    = 0;
   mem_t        m_cur;
   initial begin
      mem_gnt    = 0;
      mem_rvalid = 0;
      mem_rdata  = 0;
      forever begin
         @(negedge clk);
         mem_gnt    = 0;
         mem_rvalid = 0;
         mem_rdata  = 0;
         if (!rst_n) begin
            m_active = 0;
            rv_pend  = 0;
         end else begin
            if (rv_pend) begin
               mem_rvalid = 1;
               mem_rdata  = m_cur.rdata;
               rv_pend    = 0;
            end
            if (force_rv) begin
               mem_rvalid = 1;
               mem_rdata  = 32'hBAD0_BAD0;
               force_rv   = 0;
            end
            if (mem_req && !m_active) begin
               m_active = 1;
               m_cnt    = 0;
               if (mem_q.size() > 0) m_cur = mem_q.pop_front();
               else m_cur = '{0, 32'h0, 1'b0};
            end
            if (m_active) begin
               if (m_cnt >= m_cur.delay) begin
                  mem_gnt  = 1;
                  m_active = 0;
                  if (!mem_we && !m_cur.no_rv) rv_pend = 1;
               end else begin
                  m_cnt++;
               end
            end
         end
      end
   end

   // Monitor: samples between edges and checks against the expectation queues.
   initial begin
      req_t r;
      wb_t  w;
      int   e;
      forever begin
         @(negedge clk);
         #3;
         if (mem_req) begin
            chk("ready_during_req", in_ready, 0);
            if (req_q.size() == 0) begin
               chk("unexpected_req", mem_req, 0);
            end else begin
               r = req_q[0];
               chk("req_addr", mem_addr, r.addr);
               chk("req_we", mem_we, r.we);
               chk("req_be", mem_be, r.be);
               chk("req_wdata", mem_wdata, r.wdata);
               if (mem_gnt) void'(req_q.pop_front());
            end
         end
         if (wb_valid) begin
            if (wb_q.size() == 0) begin
               chk("unexpected_wb", wb_valid, 0);
            end else begin
               w = wb_q.pop_front();
               chk("wb_idx", wb_idx, w.idx);
               chk("wb_data", wb_data, w.data);
               chk("wb_cycle", cyc, w.cyc);
            end
         end else begin
            chk("wb_idle_zero", {wb_idx, wb_data}, 0);
         end
         if (misalign_err) begin
            if (err_q.size() == 0) begin
               chk("unexpected_err", misalign_err, 0);
            end else begin
               e = err_q.pop_front();
               chk("err_cycle", cyc, e);
            end
         end
      end
   end

   task automatic issue(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] sz, input logic u, input logic [5:0] idx,
                        output int acc);
      int n;
      @(negedge clk);
      in_valid = 1; rd_en = r; wr_en = w; rd_addr = a; wr_addr = a; wr_data = d;
      size = sz; load_unsigned = u; rd_idx = idx;
      n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk("accept_timeout", in_ready, 1);
      @(posedge clk);
      #1;
      acc = cyc;
      in_valid = 0;
   endtask

   task automatic do_load(input logic [31:0] a, input logic [1:0] sz, input logic u,
                          input logic [5:0] idx, input logic [31:0] rdata,
                          input logic [3:0] be, input logic [31:0] expd, input bit no_rv,
                          output int acc);
      mem_q.push_back('{0, rdata, no_rv});
      issue(1, 0, a, 32'h0, sz, u, idx, acc);
      req_q.push_back('{{a[31:2], 2'b00}, 1'b0, be, 32'h0});
      if (!no_rv) wb_q.push_back('{idx, expd, acc + 2});
   endtask

   task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                           input int delay, input logic [3:0] be, input logic [31:0] expw,
                           output int acc);
      mem_q.push_back('{delay, 32'h0, 1'b0});
      issue(0, 1, a, d, sz, 1'b0, 6'd0, acc);
      req_q.push_back('{{a[31:2], 2'b00}, 1'b1, be, expw});
   endtask

   task automatic do_err(input logic r, input logic w, input logic [31:0] a,
                         input logic [1:0] sz);
      int acc;
      issue(r, w, a, 32'h1234_5678, sz, 1'b0, 6'd7, acc);
      err_q.push_back(acc);
   endtask

   task automatic wait_ready(output int at);
      int n;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk("ready_timeout", in_ready, 1);
      at = cyc;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int a;
      int b;
      int t;
      rst_n = 0; in_valid = 0; rd_en = 0; wr_en = 0; rd_addr = 0; wr_addr = 0;
      wr_data = 0; size = 0; load_unsigned = 0; rd_idx = 0;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_mem_bus", {mem_we, mem_be, mem_addr, mem_wdata}, 0);
      chk("rst_wb", {wb_valid, wb_idx, wb_data}, 0);
      chk("rst_err", misalign_err, 0);
      #2 rst_n = 1;
      repeat (2) @(negedge clk);

      // Word load, best-case latency
      do_load(32'h1004, 2'b10, 1'b0, 6'd5, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF, 0, a);
      wait_ready(t);
      chk("load_next_ready", t, a + 3);

      // Byte loads at offset 3, signed then unsigned
      do_load(32'h2003, 2'b00, 1'b0, 6'd1, 32'h80FF_1234, 4'b1000, 32'hFFFF_FF80, 0, a);
      do_load(32'h2003, 2'b00, 1'b1, 6'd2, 32'h80FF_1234, 4'b1000, 32'h0000_0080, 0, a);
      // Signed half load at offset 2
      do_load(32'h2002, 2'b01, 1'b0, 6'd3, 32'h80FF_1234, 4'b1100, 32'hFFFF_80FF, 0, a);

      // Half store with grant delayed three cycles
      do_store(32'h3002, 32'h0000_ABCD, 2'b01, 3, 4'b1100, 32'hABCD_0000, a);
      wait_ready(t);
      chk("store_ready_after_gnt", t, a + 4);

      // Byte store on lane 1
      do_store(32'h6001, 32'h1234_5678, 2'b00, 0, 4'b0010, 32'h0000_7800, a);

      // Rejected transactions
      do_err(1'b1, 1'b0, 32'h4001, 2'b10);
      do_err(1'b1, 1'b0, 32'h5000, 2'b11);
      do_err(1'b0, 1'b1, 32'h5001, 2'b01);
      do_err(1'b1, 1'b1, 32'h9000, 2'b10);

      // Back-to-back: store presented while load is in flight, then a NOP
      do_load(32'h7000, 2'b10, 1'b0, 6'd9, 32'h1122_3344, 4'b1111, 32'h1122_3344, 0, a);
      do_store(32'h7004, 32'hCAFE_F00D, 2'b10, 0, 4'b1111, 32'hCAFE_F00D, b);
      chk("b2b_second_accept", b, a + 4);
      issue(1'b0, 1'b0, 32'h7008, 32'h0, 2'b10, 1'b0, 6'd0, b);
      @(negedge clk);
      chk("nop_ready", in_ready, 1);
      repeat (3) @(negedge clk);

      // Reset while waiting for read data, then a stray rvalid
      do_load(32'h8000, 2'b10, 1'b0, 6'd4, 32'h0, 4'b1111, 32'h0, 1, a);
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 0;
      #1;
      chk("midrst_req", mem_req, 0);
      chk("midrst_ready", in_ready, 1);
      chk("midrst_wb", wb_valid, 0);
      @(negedge clk);
      #2 rst_n = 1;
      @(posedge clk);
      #1 force_rv = 1;
      repeat (3) @(negedge clk);
      chk("stray_rv_ready", in_ready, 1);
      chk("stray_rv_req", mem_req, 0);
      do_load(32'h8008, 2'b01, 1'b1, 6'd12, 32'h55AA_F00F, 4'b0011, 32'h0000_F00F, 0, a);

      repeat (10) @(negedge clk);
      chk("req_q_drained", req_q.size(), 0);
      chk("wb_q_drained", wb_q.size(), 0);
      chk("err_q_drained", err_q.size(), 0);
      chk("mem_q_drained", mem_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/lsu_mem_access.md
Name: lsu_mem_access

Overview:
Memory-access stage of the LSU, directly downstream of the LSU execute stage. Accepts one load or store per transaction, using the effective address, store data and enables that the execute stage has already computed.
Drives a request/grant/response data-memory port, generating byte enables and lane-aligned store data. For loads, extracts and extends the addressed sub-word and presents it to writeback.
Processes one transaction at a time and back-pressures upstream through in_ready.

Parameters:
ADDR_W, 32, address width of rd_addr/wr_addr/mem_addr
DATA_W, 32, data width; fixed at 32 for lane logic (4 byte lanes)
REG_IDX_W, 6, destination register index width carried to writeback

Ports:
clk  input  1  clock
rst_n  input  1  reset; asynchronous, active-low
in_valid  input  1  upstream transaction present
in_ready  output  1  stage can accept (high only in IDLE)
rd_en  input  1  load request
rd_addr  input  ADDR_W  load byte address
wr_en  input  1  store request
wr_addr  input  ADDR_W  store byte address
wr_data  input  DATA_W  store data, right-justified
size  input  2  00 byte, 01 half, 10 word, 11 illegal
load_unsigned  input  1  1 = zero-extend load, 0 = sign-extend
rd_idx  input  REG_IDX_W  load destination register
mem_req  output  1  memory request, held until granted
mem_we  output  1  1 = write
mem_addr  output  ADDR_W  word-aligned address ([1:0] = 0)
mem_be  output  4  byte enables
mem_wdata  output  DATA_W  lane-aligned store data
mem_gnt  input  1  request accepted this cycle
mem_rvalid  input  1  read data valid
mem_rdata  input  DATA_W  read word
wb_valid  output  1  one-cycle pulse, load result valid
wb_idx  output  REG_IDX_W  destination register
wb_data  output  DATA_W  extended load data
misalign_err  output  1  one-cycle pulse, transaction rejected

Behaviour:
- Reset (async, rst_n low): state IDLE. All outputs 0 except in_ready=1. Latched operands cleared.
- Reset mid-transaction: mem_req drops immediately. Any later mem_rvalid/mem_gnt is ignored because IDLE does not sample them.
- FSM states:
  - IDLE: in_ready=1.
  - REQ: mem_req=1; mem_we, mem_addr, mem_be, mem_wdata driven from registered values.
  - WAIT_R: waiting for read data.
  - RESP: wb_valid=1 for one cycle.
  - ERR: misalign_err=1 for one cycle.
- Accept: in_valid && in_ready at edge T latches all inputs.
- Transitions from IDLE on accept:
  - rd_en=wr_en=0 (NOP): stay IDLE, no outputs.
  - Illegal case: rd_en&&wr_en, size=11, half with addr[0]=1, or word with addr[1:0]!=0 -> ERR (misalign_err at T+1), then IDLE. No memory access, no wb.
  - Otherwise -> REQ at T+1.
- REQ: held until the mem_gnt edge.
  - Store -> IDLE.
  - Load -> WAIT_R.
- WAIT_R: mem_rvalid -> capture data, go to RESP. mem_rvalid in any other state is ignored. Memory guarantees rvalid at least one cycle after gnt.
- RESP -> IDLE.
- Best-case latency:
  - Load: accept T, req+gnt T+1, rvalid T+2, wb_valid T+3, next accept T+4.
  - Store: accept T, req+gnt T+1, next accept T+2.
- Address: mem_addr = {addr[ADDR_W-1:2],2'b00}; off = addr[1:0].
- Byte enables:
  - byte: 4'b0001<<off
  - half: 4'b0011<<off (off in {0,2})
  - word: 4'b1111
  - Loads drive the same mem_be.
- mem_wdata = wr_data<<(8*off), masked to the enabled lanes; disabled lanes are 0.
- Load extraction: lane = mem_rdata>>(8*off); byte uses [7:0], half uses [15:0]. Bit 7/15 extends when load_unsigned=0, zeros when 1. Word passes through.
- wb_data and wb_idx are registered and held stable while wb_valid=1; they are 0 otherwise.
- The address computation wraps modulo 2^ADDR_W upstream; no overflow checks here.

Decomposition:
- Package lsu_pkg:
  - size enum SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
  - FSM state enum (IDLE, REQ, WAIT_R, RESP, ERR).
  - Constant NUM_LANES=4.
- Sub-module lsu_align (purely combinational, reused by a future cache path). Inputs: size, off, load_unsigned, wr_data, mem_rdata. Outputs: mem_be, aligned wdata, extended load data, misaligned flag.

Test Plan:
- Word load: rd_addr=0x1004, rdata=0xDEADBEEF, gnt on first req cycle, rvalid next cycle -> mem_addr=0x1004, be=1111, wb_data=0xDEADBEEF at T+3, wb_idx matches.
- Signed/unsigned byte loads at 0x2003, rdata=0x80FF_1234 -> be=1000; signed wb_data=0xFFFFFF80; unsigned wb_data=0x00000080.
- Half store: wr_addr=0x3002, wr_data=0x0000ABCD, gnt delayed 3 cycles -> mem_req held 4 cycles with stable mem_addr=0x3000, be=1100, wdata=0xABCD0000; in_ready low throughout, high the cycle after gnt.
- Misaligned word load at 0x4001, and size=11 -> misalign_err pulse at T+1, mem_req never asserted, no wb_valid.
- Back-to-back: in_valid held with a load then a store -> second accepted only when in_ready returns. The NOP case (rd_en=wr_en=0) is accepted with no mem_req.
- Reset while in WAIT_R, then a stray rvalid -> mem_req/wb_valid stay 0, in_ready=1, next load completes normally.
